// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and operand/accumulator types for the MAC processing element and the systolic array top.
package mac_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    typedef logic [DEF_DATA_W-1:0] operand_t;
    typedef logic [2*DEF_DATA_W-1:0] product_t;
    typedef logic [DEF_ACC_W-1:0] acc_t;
endpackage

// File: rtl/mac_mult.sv
// mac_mult: unsigned DATA_W x DATA_W combinational multiplier, kept separate so it can map to a DSP slice.
module mac_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_p
);
    always_comb o_p = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
endmodule

// File: rtl/mac_pe.sv
// mac_pe: systolic-array processing element forwarding a/b east/south and accumulating a*b modulo 2^ACC_W.
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_x,
    output logic [DATA_W-1:0] o_y,
    output logic [ACC_W-1:0]  o_out
);
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   x_q, y_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    mac_mult #(.DATA_W(DATA_W)) u_mult (
        .i_a(i_a),
        .i_b(i_b),
        .o_p(prod)
    );
    // Product is unsigned, so the cast zero-extends; the add wraps silently.
    always_comb acc_d = acc_q + ACC_W'(prod);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else begin
            x_q   <= i_a;
            y_q   <= i_b;
            acc_q <= acc_d;
        end
    end
    assign o_x   = x_q;
    assign o_y   = y_q;
    assign o_out = acc_q;
endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed and random checks of mac_pe against a sum-of-products reference model.
module tb_mac_pe;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_a, i_b;
    logic [7:0]  o_x, o_y;
    logic [15:0] o_out;
    int n_chk  = 0;
    int n_fail = 0;
    int exp_sum = 0;

    mac_pe dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_a(i_a),
        .i_b(i_b),
        .o_x(o_x),
        .o_y(o_y),
        .o_out(o_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one operand pair, let one edge pass, then check against the model.
    task automatic step(input int a, input int b, input string tag);
        i_a = 8'(a);
        i_b = 8'(b);
        @(posedge i_clk);
        #1;
        exp_sum = (exp_sum + a * b) % 65536;
        chk({tag, ".x"}, 32'(o_x), 32'(a));
        chk({tag, ".y"}, 32'(o_y), 32'(b));
        chk({tag, ".out"}, 32'(o_out), 32'(exp_sum));
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic pulse_rst(input string tag);
        #1 i_rst = 1'b1;
        #1;
        chk({tag, ".x"}, 32'(o_x), 0);
        chk({tag, ".y"}, 32'(o_y), 0);
        chk({tag, ".out"}, 32'(o_out), 0);
        exp_sum = 0;
        #1 i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_a = 8'd5;
        i_b = 8'd6;
        @(posedge i_clk);
        #1;
        chk("rst_hold.x", 32'(o_x), 0);
        chk("rst_hold.y", 32'(o_y), 0);
        chk("rst_hold.out", 32'(o_out), 0);
        #2 i_rst = 1'b0;
        step(3, 7, "fwd");
        chk("fwd.out21", 32'(o_out), 21);
        pulse_rst("async_rst");
        step(2, 3, "acc1");
        step(4, 5, "acc2");
        step(9, 9, "acc3");
        chk("acc.107", 32'(o_out), 107);
        step(0, 0, "zero");
        chk("zero.hold", 32'(o_out), 107);
        pulse_rst("rst_wrap");
        step(255, 255, "wrap1");
        chk("wrap1.65025", 32'(o_out), 65025);
        step(255, 255, "wrap2");
        chk("wrap2.64514", 32'(o_out), 64514);
        pulse_rst("rst_mid0");
        step(5, 10, "mid50");
        chk("mid.50", 32'(o_out), 50);
        pulse_rst("mid_rst");
        step(1, 1, "mid_resume");
        chk("mid.resume1", 32'(o_out), 1);
        for (int i = 0; i < 8; i++) step(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), "rnd_small");
        for (int i = 0; i < 30; i++) step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rnd_full");
        pulse_rst("final_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_pe.md
MAC_PE -- requirements
Module: mac_pe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port `i_clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port `i_rst`, input, 1 bit: asynchronous active-high reset; clears all state immediately when high.
REQ-004 Port `i_a`, input, 8 bits: unsigned row operand, sampled each rising edge.
REQ-005 Port `i_b`, input, 8 bits: unsigned column operand, sampled each rising edge.
REQ-006 Port `o_x`, output, 8 bits: registered copy of `i_a`, forwarded to the east neighbour.
REQ-007 Port `o_y`, output, 8 bits: registered copy of `i_b`, forwarded to the south neighbour.
REQ-008 Port `o_out`, output, 16 bits: registered accumulator value.
REQ-009 Parameter `DATA_W`, default 8: operand and forward width.
REQ-010 Parameter `ACC_W`, default 16: accumulator width; SHALL be at least 2*`DATA_W`.

Function
REQ-011 On each rising edge with `i_rst` low, `o_x` SHALL load `i_a` and `o_y` SHALL load `i_b` (latency 1 cycle).
REQ-012 On each rising edge with `i_rst` low, `o_out` SHALL load `o_out` + (`i_a` * `i_b`), using values sampled at that edge.
- Product: unsigned, full 2*`DATA_W` width, zero-extended to `ACC_W`.
- Result is visible 1 cycle after the operands are sampled.
REQ-013 The accumulation SHALL be modulo 2^`ACC_W`: overflow wraps silently, with no saturation and no flag.
REQ-014 There SHALL be no enable and no clear input; the block accumulates on every non-reset cycle, including zero operands (which add 0).
REQ-015 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.
REQ-016 Operands SHALL be treated as unsigned over the full range 0..255; no value is illegal.

Reset
REQ-017 While `i_rst` is high, `o_x`, `o_y` and `o_out` SHALL be 0.
- Asynchronous assertion: outputs clear without waiting for a clock edge.
REQ-018 Reset asserted mid-accumulation SHALL discard the running sum.
REQ-019 On the first rising edge after `i_rst` deasserts, the block SHALL resume per REQ-011 and REQ-012 starting from 0.

Structure
REQ-020 A shared package `mac_pkg` SHALL hold the `DATA_W` and `ACC_W` defaults and the operand/accumulator typedefs, for reuse by the systolic array top.
REQ-021 The multiply SHALL be isolated in one combinational sub-module `mac_mult`: unsigned `DATA_W` x `DATA_W` to 2*`DATA_W`.
REQ-022 The forwarding registers and the accumulator SHALL live in `mac_pe`.
REQ-023 The design SHALL be synthesizable for FPGA.
- No latches.
- The multiplier may map to a DSP slice.

Verification
REQ-024 Reset: with outputs non-zero, assert `i_rst` between clock edges -> `o_x`, `o_y`, `o_out` read 0 before the next edge.
REQ-025 Forwarding: drive `i_a`=3, `i_b`=7 for one edge -> after that edge `o_x`=3, `o_y`=7, `o_out`=21.
REQ-026 Accumulation: after reset, drive (a,b) = (2,3), (4,5), (9,9), one pair per cycle -> `o_out` reads 6, 26, 107 after successive edges; `o_x`/`o_y` track one cycle behind the inputs.
REQ-027 Wrap: accumulate 255*255 (65025) twice -> `o_out` = 65025, then (130050 mod 65536) = 64514.
REQ-028 Mid-run reset: accumulate to 50, pulse `i_rst`, then drive (1,1) -> `o_out` reads 0 during reset and 1 after the next edge.
REQ-029 Random: 4+ cycles of random operands below 10 -> `o_out` matches a reference model sum of products each cycle.
